// File: rtl/fp_addsub_pipe.sv
// Four-stage IEEE-754 style add/sub with flush-to-zero, specials and exception flags.
// Define FP_ADDSUB_RNE_EN for round-to-nearest-even; otherwise results are truncated.
module fp_addsub_pipe #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 23
) (
  input  logic                  in_clk,
  input  logic                  in_rst,
  input  logic                  in_valid,
  output logic                  out_ready_in,
  input  logic [EXP_W+MANT_W:0] in_numA,
  input  logic [EXP_W+MANT_W:0] in_numB,
  input  logic                  in_ctrl_addsub,
  output logic                  out_valid,
  input  logic                  in_ready,
  output logic [EXP_W+MANT_W:0] out_data,
  output logic [3:0]            out_flags
);
  localparam int W   = 1 + EXP_W + MANT_W;
  localparam int M   = MANT_W + 4;            // hidden + fraction + G/R/S
  localparam int EW  = EXP_W + 2;
  localparam int SHW = $clog2(M + 1);
  localparam logic [EXP_W-1:0] EMAX = '1;
  localparam logic [W-1:0] QNAN = {1'b0, EMAX, 1'b1, {(MANT_W-1){1'b0}}};

  logic       en;
  logic [4:1] vld_q;

  assign en           = in_ready | ~vld_q[4];
  assign out_ready_in = en;
  assign out_valid    = vld_q[4];

  // S1: unpack, classify, order by magnitude
  logic              sa, sb, za, zb, a_nan, b_nan, a_inf, b_inf, swap;
  logic [EXP_W-1:0]  ea, eb;
  logic [MANT_W-1:0] fa, fb;
  logic              s1_spec_d, s1_inv_d, s1_sign_d, s1_zsign_d, s1_sub_d;
  logic [W-1:0]      s1_sdata_d;
  logic [EXP_W-1:0]  s1_exp_d, s1_diff_d;
  logic [MANT_W:0]   s1_ml_d, s1_ms_d;

  logic              s1_spec_q, s1_inv_q, s1_sign_q, s1_zsign_q, s1_sub_q;
  logic [W-1:0]      s1_sdata_q;
  logic [EXP_W-1:0]  s1_exp_q, s1_diff_q;
  logic [MANT_W:0]   s1_ml_q, s1_ms_q;

  always_comb begin
    sa    = in_numA[W-1];
    ea    = in_numA[MANT_W +: EXP_W];
    za    = (ea == '0);
    fa    = za ? '0 : in_numA[MANT_W-1:0];
    sb    = in_numB[W-1] ^ in_ctrl_addsub;
    eb    = in_numB[MANT_W +: EXP_W];
    zb    = (eb == '0);
    fb    = zb ? '0 : in_numB[MANT_W-1:0];
    a_nan = (ea == EMAX) && (fa != '0);
    a_inf = (ea == EMAX) && (fa == '0);
    b_nan = (eb == EMAX) && (fb != '0);
    b_inf = (eb == EMAX) && (fb == '0);
    swap  = {eb, fb} > {ea, fa};

    s1_sign_d  = swap ? sb : sa;
    s1_exp_d   = swap ? eb : ea;
    s1_diff_d  = swap ? eb - ea : ea - eb;
    s1_ml_d    = swap ? {~zb, fb} : {~za, fa};
    s1_ms_d    = swap ? {~za, fa} : {~zb, fb};
    s1_sub_d   = sa ^ sb;
    s1_zsign_d = sa & sb;
    s1_spec_d  = a_nan | b_nan | a_inf | b_inf;
    s1_inv_d   = a_nan | b_nan | (a_inf & b_inf & (sa ^ sb));
    s1_sdata_d = QNAN;
    if (!s1_inv_d)
      s1_sdata_d = a_inf ? {sa, EMAX, {MANT_W{1'b0}}} : {sb, EMAX, {MANT_W{1'b0}}};
  end

  // S2: align smaller operand with sticky collection, then magnitude add/sub
  logic [M-1:0]   s2_ext, s2_shf, s2_mask, s2_al;
  logic [SHW-1:0] s2_sh;
  logic [M:0]     s2_sum_d;

  logic             s2_spec_q, s2_inv_q, s2_sign_q, s2_zsign_q;
  logic [W-1:0]     s2_sdata_q;
  logic [EXP_W-1:0] s2_exp_q;
  logic [M:0]       s2_sum_q;

  always_comb begin
    s2_ext   = {s1_ms_q, 3'b000};
    s2_sh    = (32'(s1_diff_q) >= 32'(M)) ? SHW'(M) : SHW'(s1_diff_q);
    s2_shf   = s2_ext >> s2_sh;
    s2_mask  = (M'(1) << s2_sh) - M'(1);
    s2_al    = {s2_shf[M-1:1], s2_shf[0] | (|(s2_ext & s2_mask))};
    s2_sum_d = s1_sub_q ? {1'b0, s1_ml_q, 3'b000} - {1'b0, s2_al}
                        : {1'b0, s1_ml_q, 3'b000} + {1'b0, s2_al};
  end

  // S3: leading-zero count and normalise; the hidden bit is dropped here
  logic [SHW-1:0] s3_lz;
  logic           s3_zero_d, s3_uf_d;
  logic [EW-1:0]  s3_exp_d;
  logic [M-2:0]   s3_norm_d;

  logic             s3_spec_q, s3_inv_q, s3_sign_q, s3_zsign_q, s3_zero_q, s3_uf_q;
  logic [W-1:0]     s3_sdata_q;
  logic [EW-1:0]    s3_exp_q;
  logic [M-2:0]     s3_norm_q;

  always_comb begin
    s3_lz = SHW'(M);
    for (int i = 0; i < M; i++)
      if (s2_sum_q[i]) s3_lz = SHW'(M - 1 - i);
    s3_zero_d = (s2_sum_q == '0);
    if (s2_sum_q[M]) begin
      s3_norm_d = {s2_sum_q[M-1:2], |s2_sum_q[1:0]};
      s3_exp_d  = EW'(s2_exp_q) + EW'(1);
      s3_uf_d   = 1'b0;
    end else begin
      s3_norm_d = s2_sum_q[M-2:0] << s3_lz;
      s3_exp_d  = EW'(s2_exp_q) - EW'(s3_lz);
      s3_uf_d   = !s3_zero_d && (EW'(s2_exp_q) <= EW'(s3_lz));
    end
  end

  // S4: round, detect overflow, pack
  logic              s4_ix, s4_inc;
  logic [MANT_W:0]   s4_frac_r;
  logic [EW-1:0]     s4_exp;
  logic [W-1:0]      out_data_d;
  logic [3:0]        out_flags_d;
  logic [W-1:0]      out_data_q;
  logic [3:0]        out_flags_q;

  always_comb begin
    s4_ix = |s3_norm_q[2:0];
`ifdef FP_ADDSUB_RNE_EN
    s4_inc    = s3_norm_q[2] & (s3_norm_q[1] | s3_norm_q[0] | s3_norm_q[3]);
    s4_frac_r = {1'b0, s3_norm_q[M-2:3]} + {{MANT_W{1'b0}}, s4_inc};
`else
    s4_inc    = 1'b0;
    s4_frac_r = {s4_inc, s3_norm_q[M-2:3]};
`endif
    // a fraction carry leaves the field all-zero, which is the renormalised value
    s4_exp = s3_exp_q + {{(EW-1){1'b0}}, s4_frac_r[MANT_W]};

    out_data_d  = {s3_sign_q, s4_exp[EXP_W-1:0], s4_frac_r[MANT_W-1:0]};
    out_flags_d = {3'b000, s4_ix};
    if (s3_spec_q) begin
      out_data_d  = s3_sdata_q;
      out_flags_d = {s3_inv_q, 3'b000};
    end else if (s3_zero_q) begin
      out_data_d  = {s3_zsign_q, {(W-1){1'b0}}};
      out_flags_d = 4'b0000;
    end else if (s3_uf_q) begin
      out_data_d  = {s3_sign_q, {(W-1){1'b0}}};
      out_flags_d = 4'b0011;
    end else if (s4_exp >= EW'(EMAX)) begin
      out_data_d  = {s3_sign_q, EMAX, {MANT_W{1'b0}}};
      out_flags_d = 4'b0101;
    end
  end

  assign out_data  = out_data_q;
  assign out_flags = out_flags_q;

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      vld_q       <= '0;
      s1_spec_q   <= 1'b0; s1_inv_q <= 1'b0; s1_sign_q <= 1'b0;
      s1_zsign_q  <= 1'b0; s1_sub_q <= 1'b0; s1_sdata_q <= '0;
      s1_exp_q    <= '0;   s1_diff_q <= '0;  s1_ml_q <= '0; s1_ms_q <= '0;
      s2_spec_q   <= 1'b0; s2_inv_q <= 1'b0; s2_sign_q <= 1'b0;
      s2_zsign_q  <= 1'b0; s2_sdata_q <= '0; s2_exp_q <= '0; s2_sum_q <= '0;
      s3_spec_q   <= 1'b0; s3_inv_q <= 1'b0; s3_sign_q <= 1'b0;
      s3_zsign_q  <= 1'b0; s3_zero_q <= 1'b0; s3_uf_q <= 1'b0;
      s3_sdata_q  <= '0;   s3_exp_q <= '0;  s3_norm_q <= '0;
      out_data_q  <= '0;
      out_flags_q <= '0;
    end else if (en) begin
      vld_q       <= {vld_q[3:1], in_valid};
      s1_spec_q   <= s1_spec_d;  s1_inv_q <= s1_inv_d;  s1_sign_q <= s1_sign_d;
      s1_zsign_q  <= s1_zsign_d; s1_sub_q <= s1_sub_d;  s1_sdata_q <= s1_sdata_d;
      s1_exp_q    <= s1_exp_d;   s1_diff_q <= s1_diff_d;
      s1_ml_q     <= s1_ml_d;    s1_ms_q <= s1_ms_d;
      s2_spec_q   <= s1_spec_q;  s2_inv_q <= s1_inv_q;  s2_sign_q <= s1_sign_q;
      s2_zsign_q  <= s1_zsign_q; s2_sdata_q <= s1_sdata_q;
      s2_exp_q    <= s1_exp_q;   s2_sum_q <= s2_sum_d;
      s3_spec_q   <= s2_spec_q;  s3_inv_q <= s2_inv_q;  s3_sign_q <= s2_sign_q;
      s3_zsign_q  <= s2_zsign_q; s3_zero_q <= s3_zero_d; s3_uf_q <= s3_uf_d;
      s3_sdata_q  <= s2_sdata_q; s3_exp_q <= s3_exp_d;  s3_norm_q <= s3_norm_d;
      out_data_q  <= out_data_d;
      out_flags_q <= out_flags_d;
    end
  end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Scoreboard bench for fp_addsub_pipe: expected results come from an exact wide-integer
// reference (or hand constants) and are checked by a decoupled output monitor.
module tb_fp_addsub_pipe;
  localparam int EXP_W = 8, MANT_W = 23;

  logic        in_clk = 1'b0, in_rst = 1'b1, in_valid = 1'b0, in_ready = 1'b1, in_ctrl_addsub = 1'b0;
  logic [31:0] in_numA = '0, in_numB = '0;
  logic        out_ready_in, out_valid;
  logic [31:0] out_data;
  logic [3:0]  out_flags;

  fp_addsub_pipe #(.EXP_W(EXP_W), .MANT_W(MANT_W)) dut (
    .in_clk(in_clk), .in_rst(in_rst), .in_valid(in_valid), .out_ready_in(out_ready_in),
    .in_numA(in_numA), .in_numB(in_numB), .in_ctrl_addsub(in_ctrl_addsub),
    .out_valid(out_valid), .in_ready(in_ready), .out_data(out_data), .out_flags(out_flags));

  always #5 in_clk = ~in_clk;

  typedef struct packed {
    logic [31:0] a, b;
    logic        c;
    logic [31:0] d;
    logic [3:0]  f;
  } exp_t;

  exp_t sbq[$];
  int checks = 0, errors = 0, n_pushed = 0, n_popped = 0;
  logic        stalled_prev = 1'b0;
  logic [35:0] held = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %h required %h", nm, act, req);
    end
  endtask

  // Exact reference: operands become integers scaled by 2^(e-1), summed without loss.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic c);
    exp_t r;
    logic sa, sb, s, g, st, inc;
    logic [7:0] ea, eb;
    logic [22:0] fa, fb;
    logic [299:0] va, vb, t, lowm;
    logic [24:0] keep;
    int msb, e, sh;
    r.a = a; r.b = b; r.c = c; r.f = 4'b0000;
    sa = a[31]; ea = a[30:23]; fa = a[22:0];
    sb = b[31] ^ c; eb = b[30:23]; fb = b[22:0];
    if ((ea == 8'hFF && fa != 0) || (eb == 8'hFF && fb != 0) ||
        (ea == 8'hFF && eb == 8'hFF && sa != sb)) begin
      r.d = 32'h7FC00000; r.f = 4'b1000; return r;
    end
    if (ea == 8'hFF) begin r.d = {sa, 8'hFF, 23'h0}; return r; end
    if (eb == 8'hFF) begin r.d = {sb, 8'hFF, 23'h0}; return r; end
    va = (ea == 0) ? '0 : (300'({1'b1, fa}) << (ea - 8'd1));
    vb = (eb == 0) ? '0 : (300'({1'b1, fb}) << (eb - 8'd1));
    if (sa == sb)      begin t = va + vb; s = sa; end
    else if (va >= vb) begin t = va - vb; s = sa; end
    else               begin t = vb - va; s = sb; end
    if (t == 0) begin r.d = {sa & sb, 31'h0}; return r; end
    msb = 0;
    for (int i = 0; i < 300; i++) if (t[i]) msb = i;
    e = msb - 22;
    if (e < 1) begin r.d = {s, 31'h0}; r.f = 4'b0011; return r; end
    sh = msb - 23;
    keep = 25'(t >> sh);
    g = 1'b0; st = 1'b0;
    if (sh > 0) begin
      g = t[sh-1];
      lowm = (300'(1) << (sh - 1)) - 300'(1);
      st = |(t & lowm);
    end
`ifdef FP_ADDSUB_RNE_EN
    inc = g & (st | keep[0]);
`else
    inc = 1'b0;
`endif
    keep = keep + 25'(inc);
    if (keep[24]) begin keep = keep >> 1; e++; end
    if (e >= 255) begin r.d = {s, 8'hFF, 23'h0}; r.f = 4'b0101; return r; end
    r.d = {s, 8'(e), keep[22:0]};
    r.f = {3'b000, g | st};
    return r;
  endfunction

  function automatic exp_t mk(input logic [31:0] a, b, input logic c, input logic [31:0] d,
                              input logic [3:0] f);
    exp_t r;
    r.a = a; r.b = b; r.c = c; r.d = d; r.f = f;
    return r;
  endfunction

  function automatic logic [31:0] rnd_num(input int near);
    int k, e;
    logic [31:0] fr;
    k  = int'($urandom_range(0, 19));
    fr = $urandom;
    if (k == 0)       e = 0;
    else if (k == 1)  e = 255;
    else if (k < 12)  e = near + int'($urandom_range(0, 50)) - 25;
    else              e = int'($urandom_range(1, 254));
    if (k >= 2 && e < 1)   e = 1;
    if (k >= 2 && e > 254) e = 254;
    if (k < 2 && $urandom_range(0, 1) == 0) fr = '0;
    return {1'($urandom), 8'(e), fr[22:0]};
  endfunction

  // Caller is positioned just after a rising edge; returns just after the accepting edge.
  task automatic send(input exp_t e);
    int t = 0;
    in_numA = e.a; in_numB = e.b; in_ctrl_addsub = e.c; in_valid = 1'b1;
    @(negedge in_clk);
    while (!out_ready_in && t < 100) begin @(negedge in_clk); t++; end
    chk("accept_in_time", {63'b0, out_ready_in}, 64'd1);
    if (out_ready_in) begin sbq.push_back(e); n_pushed++; end
    @(posedge in_clk); #1 in_valid = 1'b0;
  endtask

  task automatic lat_check(input string nm);
    int n = 0;
    do begin @(negedge in_clk); n++; end while (!out_valid && n < 20);
    chk(nm, 64'(n), 64'd4);
  endtask

  task automatic drain();
    int t = 0;
    in_ready = 1'b1;
    while (sbq.size() != 0 && t < 300) begin @(posedge in_clk); t++; end
    chk("drain", 64'(sbq.size()), 64'd0);
    @(posedge in_clk); #1;
  endtask

  always @(negedge in_clk) begin
    if (in_rst) begin
      stalled_prev = 1'b0;
    end else begin
      if (stalled_prev && out_valid) chk("stall_hold", 64'({out_data, out_flags}), 64'(held));
      if (out_valid && in_ready) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output: actual %h/%b required none", out_data, out_flags);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk($sformatf("data a=%h b=%h c=%0d", e.a, e.b, e.c), 64'(out_data), 64'(e.d));
          chk($sformatf("flags a=%h b=%h c=%0d", e.a, e.b, e.c), 64'(out_flags), 64'(e.f));
          n_popped++;
        end
      end
      stalled_prev = out_valid && !in_ready;
      held = {out_data, out_flags};
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b;
    logic        rnd_done;
    int          v, flushed;
    rnd_done = 1'b0;
    repeat (2) @(negedge in_clk);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_flags", 64'(out_flags), 64'd0);
    @(posedge in_clk); #1 in_rst = 1'b0;
    @(posedge in_clk); #1;

    send(mk(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000));
    lat_check("latency_first");
    drain();

    send(mk(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000));
    send(mk(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101));
    send(mk(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000));
    send(mk(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001));
`ifdef FP_ADDSUB_RNE_EN
    send(mk(32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 4'b0001));
`else
    send(mk(32'h3F800000, 32'h33800001, 1'b0, 32'h3F800000, 4'b0001));
`endif
    send(mk(32'h00000000, 32'hC0A00000, 1'b0, 32'hC0A00000, 4'b0000));
    send(mk(32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 4'b0000));
    send(mk(32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 4'b0011));
    send(mk(32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000));
    send(mk(32'h3F800000, 32'hFF800000, 1'b0, 32'hFF800000, 4'b0000));
    drain();

    fork
      begin
        for (int i = 0; i < 6; i++) begin
          logic [31:0] x, y;
          x = rnd_num(127); y = rnd_num(int'(x[30:23]));
          send(model(x, y, 1'($urandom)));
        end
      end
      begin
        repeat (5) @(posedge in_clk);
        #1 in_ready = 1'b0;
        repeat (3) begin
          @(negedge in_clk);
          chk("stall_ready_low", 64'(out_ready_in), 64'd0);
        end
        @(posedge in_clk); #1 in_ready = 1'b1;
      end
    join
    drain();

    fork
      begin
        for (int i = 0; i < 500; i++) begin
          a = rnd_num(int'($urandom_range(1, 254)));
          if ($urandom_range(0, 7) == 0) begin
            b = a ^ 32'($urandom_range(0, 255));
            b[31] = 1'($urandom);
          end else begin
            b = rnd_num(int'(a[30:23]));
          end
          if ($urandom_range(0, 3) == 0) begin @(posedge in_clk); #1; end
          send(model(a, b, 1'($urandom)));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge in_clk); #1 in_ready = ($urandom_range(0, 9) < 7);
        end
        in_ready = 1'b1;
      end
    join
    drain();

    for (int i = 0; i < 3; i++) begin
      a = rnd_num(100); b = rnd_num(100);
      send(model(a, b, 1'b0));
    end
    in_rst = 1'b1;
    #1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_data", 64'(out_data), 64'd0);
    flushed = sbq.size();
    sbq.delete();
    n_pushed -= flushed;
    @(posedge in_clk); #1 in_rst = 1'b0;
    v = 0;
    repeat (8) begin @(negedge in_clk); if (out_valid) v++; end
    chk("post_rst_quiet", 64'(v), 64'd0);
    @(posedge in_clk); #1;
    send(model(32'h40490FDB, 32'hC0000000, 1'b1));
    lat_check("latency_after_rst");
    drain();

    chk("all_delivered", 64'(n_popped), 64'(n_pushed));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
